// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core (C) and loader (L).
// Owner-based round-robin with a bounded burst; grants are combinational from owner and requests.
module dmem_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  input  logic          l_req,
  input  logic          l_wr,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_wr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout
);

  localparam int            CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  owner_t        owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          own_req, oth_req;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_C;
      cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt counts contested cycles already granted to the owner; it never passes LAST.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    owner_nxt = owner;
    cnt_nxt   = '0;
    own_req   = (owner == OWN_C) ? c_req : l_req;
    oth_req   = (owner == OWN_C) ? l_req : c_req;
    if (oth_req) begin
      if (!own_req || cnt == LAST) begin
        owner_nxt = (owner == OWN_C) ? OWN_L : OWN_C;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  assign c_gnt   = c_req & (owner == OWN_C);
  assign l_gnt   = l_req & (owner == OWN_L);
  assign c_stall = c_req & ~c_gnt;

  // Address and data follow the owner even when it is idle; only m_wr needs a grant.
  assign m_addr = (owner == OWN_C) ? c_addr  : l_addr;
  assign m_din  = (owner == OWN_C) ? c_wdata : l_wdata;
  assign m_wr   = (c_gnt & c_wr) | (l_gnt & l_wr);
  assign rdata  = m_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a grant/memory reference model.
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req, c_wr, l_req, l_wr;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic          c_gnt, c_stall, l_gnt, m_wr;
  logic [DW-1:0] rdata, m_din, m_dout;
  logic [AW-1:0] m_addr;
  // Second instance with MAX_BURST=1, driven by the same requesters.
  logic          c_gnt1, c_stall1, l_gnt1, m_wr1;
  logic [DW-1:0] rdata1, m_din1;
  logic [AW-1:0] m_addr1;
  logic [DW-1:0] m_dout1 = '0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall),
    .l_req(l_req), .l_wr(l_wr), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .rdata(rdata),
    .m_addr(m_addr), .m_wr(m_wr), .m_din(m_din), .m_dout(m_dout)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_stall(c_stall1),
    .l_req(l_req), .l_wr(l_wr), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt1), .rdata(rdata1),
    .m_addr(m_addr1), .m_wr(m_wr1), .m_din(m_din1), .m_dout(m_dout1)
  );

  always #5 clk = ~clk;

  // Data memory driven by the DUT: combinational read, clocked write.
  logic [DW-1:0] mem [2**AW];
  assign m_dout = mem[m_addr];
  always @(posedge clk) if (m_wr) mem[m_addr] <= m_din;

  // Reference model: who holds the memory, and how many grants it has taken while the other waited.
  int            ref_owner  = 0;  // 0 = core, 1 = loader
  int            ref_streak = 0;
  logic [DW-1:0] ref_mem [2**AW];
  logic          mo_req, mx_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_owner  = 0;
      ref_streak = 0;
    end else begin
      if (ref_owner == 0 && c_req && c_wr) ref_mem[c_addr] = c_wdata;
      if (ref_owner == 1 && l_req && l_wr) ref_mem[l_addr] = l_wdata;
      mo_req = (ref_owner == 0) ? c_req : l_req;
      mx_req = (ref_owner == 0) ? l_req : c_req;
      if (!mx_req) begin
        ref_streak = 0;
      end else if (!mo_req) begin
        ref_owner  = 1 - ref_owner;
        ref_streak = 0;
      end else begin
        ref_streak = ref_streak + 1;
        if (ref_streak >= MB) begin
          ref_owner  = 1 - ref_owner;
          ref_streak = 0;
        end
      end
    end
  end

  typedef struct packed {
    logic          cg;
    logic          lg;
    logic          cs;
    logic          mw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } obs_t;

  function automatic obs_t model_out();
    obs_t e;
    e.cg = c_req && (ref_owner == 0);
    e.lg = l_req && (ref_owner == 1);
    e.cs = c_req && !e.cg;
    e.mw = (e.cg && c_wr) || (e.lg && l_wr);
    e.a  = (ref_owner == 0) ? c_addr : l_addr;
    e.d  = (ref_owner == 0) ? c_wdata : l_wdata;
    return e;
  endfunction

  function automatic obs_t dut_out();
    return '{cg: c_gnt, lg: l_gnt, cs: c_stall, mw: m_wr, a: m_addr, d: m_din};
  endfunction

  task automatic drive_c(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_req = req; c_wr = wr; c_addr = a; c_wdata = d;
  endtask

  task automatic drive_l(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    l_req = req; l_wr = wr; l_addr = a; l_wdata = d;
  endtask

  task automatic test_reset();
    drive_c(1'b1, 1'b0, 6'd5, 32'h0);
    drive_l(1'b1, 1'b0, 6'd9, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({c_gnt, l_gnt, c_stall, m_wr, m_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd5}) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got gnt_c=%b gnt_l=%b stall=%b wr=%b addr=%0d, want 1 0 0 0 5",
                 i, c_gnt, l_gnt, c_stall, m_wr, m_addr);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_l(1'b0, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic test_core_write();
    obs_t e;
    drive_c(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      e = model_out();
      checks++;
      if (c_gnt !== 1'b1 || c_stall !== 1'b0 || dut_out() !== e) begin
        errors++;
        $display("FAIL core_write cyc%0d: got %h, want %h (gnt=1 stall=0)", i, dut_out(), e);
      end
    end
    @(negedge clk);
    drive_c(1'b1, 1'b0, 6'd5, 32'h0);
    #1;
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_readback: got %h, want deadbeef", rdata);
    end
  endtask

  task automatic test_loader_handover();
    @(negedge clk);
    drive_c(1'b0, 1'b0, 6'd0, 32'h0);
    drive_l(1'b1, 1'b1, 6'd3, 32'h12345678);
    #1;
    checks++;
    if (l_gnt !== 1'b0 || m_wr !== 1'b0) begin
      errors++;
      $display("FAIL loader_cycle0: got l_gnt=%b m_wr=%b, want 0 0", l_gnt, m_wr);
    end
    @(negedge clk); #1;
    checks++;
    if (l_gnt !== 1'b1 || m_wr !== 1'b1 || m_addr !== 6'd3 || m_din !== 32'h12345678) begin
      errors++;
      $display("FAIL loader_cycle1: got l_gnt=%b m_wr=%b addr=%0d din=%h, want 1 1 3 12345678",
               l_gnt, m_wr, m_addr, m_din);
    end
    @(negedge clk);
    drive_l(1'b0, 1'b0, 6'd0, 32'h0);
    drive_c(1'b1, 1'b0, 6'd3, 32'h0);
    #1;
    checks++;
    if (c_stall !== 1'b1 || c_gnt !== 1'b0) begin
      errors++;
      $display("FAIL core_regain_wait: got stall=%b gnt=%b, want 1 0", c_stall, c_gnt);
    end
    @(negedge clk); #1;
    checks++;
    if (c_gnt !== 1'b1 || rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL core_readback_loader: got gnt=%b rdata=%h, want 1 12345678", c_gnt, rdata);
    end
  endtask

  task automatic test_burst();
    obs_t e;
    logic want_c;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_c(1'b1, 1'b0, 6'(i), 32'h0);
      drive_l(1'b1, 1'b0, 6'(i + 20), 32'h0);
      #1;
      want_c = ((i / MB) % 2) == 0;
      e = model_out();
      checks++;
      if (c_gnt !== want_c || l_gnt !== !want_c || c_stall !== !want_c || dut_out() !== e) begin
        errors++;
        $display("FAIL burst cyc%0d: got gnt_c=%b gnt_l=%b stall=%b (%h), want %b %b %b (%h)",
                 i, c_gnt, l_gnt, c_stall, dut_out(), want_c, !want_c, !want_c, e);
      end
    end
  endtask

  task automatic test_drop_handover();
    @(negedge clk);
    drive_c(1'b0, 1'b0, 6'd0, 32'h0);
    drive_l(1'b1, 1'b0, 6'd7, 32'h0);
    #1;
    checks++;
    if (l_gnt !== 1'b1) begin
      errors++;
      $display("FAIL drop_owner_l: got l_gnt=%b, want 1", l_gnt);
    end
    @(negedge clk);
    drive_l(1'b0, 1'b0, 6'd7, 32'h0);
    drive_c(1'b1, 1'b1, 6'd10, 32'hCAFE0004);
    #1;
    checks++;
    if (c_gnt !== 1'b0 || c_stall !== 1'b1 || m_wr !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle_cycle: got gnt=%b stall=%b m_wr=%b, want 0 1 0", c_gnt, c_stall, m_wr);
    end
    @(negedge clk); #1;
    checks++;
    if (c_gnt !== 1'b1 || m_wr !== 1'b1) begin
      errors++;
      $display("FAIL drop_next_cycle: got gnt=%b m_wr=%b, want 1 1", c_gnt, m_wr);
    end
    @(negedge clk);
    drive_c(1'b1, 1'b0, 6'd10, 32'h0);
    #1;
    checks++;
    if (rdata !== 32'hCAFE0004) begin
      errors++;
      $display("FAIL drop_readback: got %h, want cafe0004", rdata);
    end
  endtask

  task automatic test_park();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_c(1'b0, 1'b0, 6'd0, 32'h0);
      drive_l(1'b1, 1'b1, 6'(40 + i), $urandom);
      #1;
      checks++;
      if (l_gnt !== (i > 0)) begin
        errors++;
        $display("FAIL park_lburst cyc%0d: got l_gnt=%b, want %b", i, l_gnt, (i > 0));
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_c(1'b0, 1'b1, 6'd1, 32'hFFFF0000);
      drive_l(1'b0, 1'b1, 6'd2, 32'h0000FFFF);
      #1;
      checks++;
      if (m_wr !== 1'b0 || c_gnt !== 1'b0 || l_gnt !== 1'b0 || m_addr !== 6'd2) begin
        errors++;
        $display("FAIL park_idle cyc%0d: got m_wr=%b gnt=%b%b addr=%0d, want 0 00 2",
                 i, m_wr, c_gnt, l_gnt, m_addr);
      end
    end
    @(negedge clk);
    drive_c(1'b1, 1'b0, 6'd40, 32'h0);
    drive_l(1'b0, 1'b0, 6'd2, 32'h0);
    #1;
    checks++;
    if (c_stall !== 1'b1 || c_gnt !== 1'b0) begin
      errors++;
      $display("FAIL park_wake0: got stall=%b gnt=%b, want 1 0", c_stall, c_gnt);
    end
    @(negedge clk); #1;
    checks++;
    if (c_gnt !== 1'b1 || rdata !== ref_mem[40]) begin
      errors++;
      $display("FAIL park_wake1: got gnt=%b rdata=%h, want 1 %h", c_gnt, rdata, ref_mem[40]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic want_c, want_c1;
    @(negedge clk);
    drive_c(1'b0, 1'b0, 6'd0, 32'h0);
    drive_l(1'b1, 1'b0, 6'd4, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_c(1'b1, 1'b0, 6'd8, 32'h0);
      #1;
      checks++;
      if (l_gnt !== 1'b1 || c_stall !== 1'b1) begin
        errors++;
        $display("FAIL midburst_l cyc%0d: got l_gnt=%b stall=%b, want 1 1", i, l_gnt, c_stall);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (c_gnt !== 1'b1 || l_gnt !== 1'b0 || m_addr !== 6'd8) begin
      errors++;
      $display("FAIL async_reset: got gnt_c=%b gnt_l=%b addr=%0d, want 1 0 8", c_gnt, l_gnt, m_addr);
    end
    c_req = 1'b0;
    #1;
    checks++;
    if (c_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_follow0: got gnt=%b, want 0", c_gnt);
    end
    c_req = 1'b1;
    #1;
    checks++;
    if (c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_follow1: got gnt=%b, want 1", c_gnt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      want_c  = (i < MB) || (i == 2 * MB);
      want_c1 = (i % 2) == 0;
      checks++;
      if (c_gnt !== want_c || l_gnt !== !want_c || c_gnt1 !== want_c1 || l_gnt1 !== !want_c1) begin
        errors++;
        $display("FAIL post_reset_rr cyc%0d: got b4=%b%b b1=%b%b, want b4=%b%b b1=%b%b",
                 i, c_gnt, l_gnt, c_gnt1, l_gnt1, want_c, !want_c, want_c1, !want_c1);
      end
    end
  endtask

  task automatic test_random();
    obs_t e;
    logic c_pend = 1'b0;
    logic l_pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!c_pend || $urandom_range(7) == 0)
        drive_c($urandom_range(3) != 0, 1'($urandom), 6'($urandom_range(15)), $urandom);
      if (!l_pend || $urandom_range(7) == 0)
        drive_l($urandom_range(2) == 0, 1'($urandom), 6'($urandom_range(15)), $urandom);
      #1;
      e = model_out();
      checks++;
      if (dut_out() !== e || rdata !== ref_mem[e.a]) begin
        errors++;
        $display("FAIL random cyc%0d: got %h rdata=%h, want %h rdata=%h", i, dut_out(), rdata, e, ref_mem[e.a]);
      end
      c_pend = c_req && !e.cg;
      l_pend = l_req && !e.lg;
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_core_write();
    test_loader_handover();
    test_burst();
    test_drop_handover();
    test_park();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
